ps2_event_decoder: RTL and testbench

- Sits directly downstream of the PS/2 frame receiver.
- Consumes its stream of validated scan-code bytes and folds the 0xE0 (extended), 0xF0 (break) and 0xE1 (pause) prefix sequences into single key events: code, extended flag, released flag.
- Buffers events in a small FIFO with a valid/ready handshake toward the display/consumer logic.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_event_decoder_if.sv | 21 ++
 rtl/ps2_event_fifo.sv | 36 +++
 rtl/ps2_event_decoder.sv | 98 +++++++++
 tb/tb_ps2_event_decoder.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM encoding and event layout for the PS/2 event decoder
package ps2_pkg;
    localparam logic [7:0] PS2_E0   = 8'hE0;
    localparam logic [7:0] PS2_F0   = 8'hF0;
    localparam logic [7:0] PS2_E1   = 8'hE1;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;
    localparam int PAUSE_SKIP = 7;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;
endpackage

// File: rtl/ps2_event_decoder_if.sv
// ps2_event_decoder_if: scan-byte input stream and key-event output handshake
interface ps2_event_decoder_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       parity_ok;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       overflow;
    logic       parity_err;
    modport master (
        output byte_in, byte_valid, parity_ok, ev_ready,
        input  ev_valid, ev_code, ev_ext, ev_rel, overflow, parity_err
    );
    modport slave (
        input  byte_in, byte_valid, parity_ok, ev_ready,
        output ev_valid, ev_code, ev_ext, ev_rel, overflow, parity_err
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word fall-through FIFO, head reads as zero when empty
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic wr, rd;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];
    // wrap-bit pointers; a pop frees the slot a same-cycle push into a full FIFO reuses
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wr ? wptr + 1'b1 : wptr;
            rptr <= rd ? rptr + 1'b1 : rptr;
        end
    // storage needs no reset, the head is masked while empty
    always_ff @(posedge clk)
        if (wr) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_event_decoder.sv
// ps2_event_decoder: folds E0/F0/E1 prefix sequences into key events and queues them
module ps2_event_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic clk,
    input logic rst,
    ps2_event_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [2:0] state, nstate, cur, skip, nskip;
    logic [TW-1:0] tcnt;
    logic timeout, bad, e0, f0, e1, pfx, push, pop, full, empty, ovf, perr;
    ps2_event_t ev_in, head;
    assign e0      = bus.byte_in == PS2_E0;
    assign f0      = bus.byte_in == PS2_F0;
    assign e1      = bus.byte_in == PS2_E1;
    assign pfx     = e0 || f0 || e1;
    assign bad     = !bus.parity_ok || bus.byte_in == PS2_ERR0 || bus.byte_in == PS2_ERR1;
    assign timeout = (state != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign cur     = timeout ? ST_IDLE : state;
    assign pop     = !empty && bus.ev_ready;
    // next prefix state and event to push; a byte landing on the timeout decodes from IDLE
    always_comb begin
        nstate = cur;
        nskip  = skip;
        push   = 1'b0;
        ev_in  = '{ext: 1'b0, rel: 1'b0, code: bus.byte_in};
        if (bus.byte_valid && bad)
            nstate = ST_IDLE;
        else if (bus.byte_valid)
            case (cur)
                ST_IDLE: begin
                    nstate = e0 ? ST_EXT : f0 ? ST_BRK : e1 ? ST_PAUSE : ST_IDLE;
                    nskip  = e1 ? 3'(PAUSE_SKIP) : skip;
                    push   = !pfx;
                end
                ST_EXT: begin
                    nstate    = f0 ? ST_EXT_BRK : e0 ? ST_EXT : ST_IDLE;
                    push      = !(e0 || f0);
                    ev_in.ext = 1'b1;
                end
                ST_BRK: begin
                    nstate    = f0 ? ST_BRK : e0 ? ST_EXT_BRK : ST_IDLE;
                    push      = !(e0 || f0);
                    ev_in.rel = 1'b1;
                end
                ST_EXT_BRK: begin
                    nstate    = pfx ? ST_EXT_BRK : ST_IDLE;
                    push      = !pfx;
                    ev_in.ext = 1'b1;
                    ev_in.rel = 1'b1;
                end
                ST_PAUSE: begin
                    nskip      = skip - 3'd1;
                    push       = nskip == 3'd0;
                    nstate     = push ? ST_IDLE : ST_PAUSE;
                    ev_in.code = PS2_E1;
                end
                default: nstate = ST_IDLE;
            endcase
    end
    // prefix state, pause skip count and sticky error flags
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            skip  <= '0;
            perr  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= nstate;
            skip  <= nskip;
            perr  <= perr | (bus.byte_valid & !bus.parity_ok);
            ovf   <= ovf | (push & full & !pop);
        end
    // abandonment timer: cleared by every byte, runs only while a prefix is pending
    always_ff @(posedge clk or posedge rst)
        if (rst) tcnt <= '0;
        else     tcnt <= (bus.byte_valid || cur == ST_IDLE) ? '0 : tcnt + 1'b1;
    ps2_event_fifo #(.WIDTH($bits(ps2_event_t)), .DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (ev_in),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    assign bus.ev_valid   = !empty;
    assign bus.ev_code    = head.code;
    assign bus.ev_ext     = head.ext;
    assign bus.ev_rel     = head.rel;
    assign bus.overflow   = ovf;
    assign bus.parity_err = perr;
endmodule

// File: tb/tb_ps2_event_decoder.sv
// tb_ps2_event_decoder: table-driven byte vectors plus timeout, overflow and reset sequences
module tb_ps2_event_decoder;
    localparam int T = 16;
    typedef struct {
        logic [7:0] b;
        logic       p;
        logic       v;
        logic       x;
        logic       r;
        logic [7:0] c;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    logic [7:0] drain [4];
    ps2_event_decoder_if bus();
    ps2_event_decoder #(.DEPTH(4), .TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_ev(input string name, input logic v, input logic x, input logic r, input logic [7:0] c);
        check(name, {5'd0, bus.ev_valid, bus.ev_ext, bus.ev_rel, bus.ev_code}, v ? {5'd0, 1'b1, x, r, c} : 16'd0);
    endtask

    task automatic add(input logic [7:0] b, input logic p, input logic v, input logic x, input logic r, input logic [7:0] c);
        tbl.push_back('{b, p, v, x, r, c});
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        bus.byte_in    = b;
        bus.parity_ok  = p;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        bus.ev_ready = 1'b1;
        idle(1);
        bus.ev_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.parity_ok = 1'b1;
        bus.ev_ready = 1'b0;
        add(8'h1C,1,1,0,0,8'h1C);
        add(8'hE0,1,0,0,0,0); add(8'hF0,1,0,0,0,0); add(8'h75,1,1,1,1,8'h75);
        add(8'hE1,1,0,0,0,0); add(8'h14,1,0,0,0,0); add(8'h77,1,0,0,0,0); add(8'hE1,1,0,0,0,0);
        add(8'hF0,1,0,0,0,0); add(8'h14,1,0,0,0,0); add(8'hF0,1,0,0,0,0); add(8'h77,1,1,0,0,8'hE1);
        add(8'hF0,1,0,0,0,0); add(8'h1C,1,1,0,1,8'h1C);
        add(8'hE0,1,0,0,0,0); add(8'h74,1,1,1,0,8'h74);
        add(8'hF0,1,0,0,0,0); add(8'hE0,1,0,0,0,0); add(8'h6B,1,1,1,1,8'h6B);
        add(8'hE0,1,0,0,0,0); add(8'hE0,1,0,0,0,0); add(8'hF0,1,0,0,0,0); add(8'h11,1,1,1,1,8'h11);
        add(8'hF0,1,0,0,0,0); add(8'hF0,1,0,0,0,0); add(8'h12,1,1,0,1,8'h12);
        add(8'hE0,1,0,0,0,0); add(8'h00,1,0,0,0,0); add(8'h2A,1,1,0,0,8'h2A);
        add(8'hF0,1,0,0,0,0); add(8'hFF,1,0,0,0,0); add(8'h2B,1,1,0,0,8'h2B);
        add(8'hE1,1,0,0,0,0); add(8'h14,1,0,0,0,0); add(8'h00,1,0,0,0,0); add(8'h1C,1,1,0,0,8'h1C);
        add(8'hE0,1,0,0,0,0); add(8'hF0,1,0,0,0,0); add(8'hF0,1,0,0,0,0); add(8'hE0,1,0,0,0,0);
        add(8'h5A,1,1,1,1,8'h5A);
        add(8'h1C,0,0,0,0,0);
        add(8'hE0,0,0,0,0,0); add(8'h6B,1,1,0,0,8'h6B);

        idle(2);
        check("reset_outputs", {3'd0, bus.ev_valid, bus.ev_ext, bus.ev_rel, bus.ev_code, bus.overflow, bus.parity_err}, 16'd0);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].b, tbl[i].p);
            check_ev($sformatf("vec%0d_%h", i, tbl[i].b), tbl[i].v, tbl[i].x, tbl[i].r, tbl[i].c);
            if (tbl[i].v) pop1();
        end
        check("flags_after_vectors", {14'd0, bus.overflow, bus.parity_err}, 16'h0001);

        send(8'hF0, 1); idle(T - 2); send(8'h1C, 1);
        check_ev("timeout_just_before", 1, 0, 1, 8'h1C); pop1();
        send(8'hF0, 1); idle(T - 1); send(8'h1C, 1);
        check_ev("timeout_same_cycle", 1, 0, 0, 8'h1C); pop1();
        send(8'hF0, 1); idle(T + 5);
        check_ev("timeout_no_event", 0, 0, 0, 0);
        send(8'h1C, 1);
        check_ev("timeout_after", 1, 0, 0, 8'h1C); pop1();

        bus.ev_ready = 1'b1; idle(2); bus.ev_ready = 1'b0;
        check_ev("ready_while_empty", 0, 0, 0, 0);
        send(8'h1C, 1);
        check_ev("after_empty_ready", 1, 0, 0, 8'h1C); pop1();

        send(8'h15, 1); send(8'h16, 1); send(8'h1D, 1); send(8'h1E, 1);
        check("no_overflow_at_full", {15'd0, bus.overflow}, 16'd0);
        send(8'h21, 1);
        check("overflow_set", {15'd0, bus.overflow}, 16'd1);
        check_ev("full_head", 1, 0, 0, 8'h15);
        idle(3);
        check_ev("head_stable", 1, 0, 0, 8'h15);
        drain = '{8'h16, 8'h1D, 8'h1E, 8'h26};
        bus.ev_ready = 1'b1;
        send(8'h26, 1);
        for (int i = 0; i < 4; i++) begin
            check_ev($sformatf("drain%0d", i), 1, 0, 0, drain[i]);
            idle(1);
        end
        bus.ev_ready = 1'b0;
        check_ev("drained_empty", 0, 0, 0, 0);

        send(8'h1C, 1); send(8'hE0, 1);
        check("flags_before_rst", {14'd0, bus.overflow, bus.parity_err}, 16'h0003);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", {3'd0, bus.ev_valid, bus.ev_ext, bus.ev_rel, bus.ev_code, bus.overflow, bus.parity_err}, 16'd0);
        #2 rst = 1'b0;
        idle(1);
        send(8'h75, 1);
        check_ev("prefix_lost_on_rst", 1, 0, 0, 8'h75);
        pop1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
